// File: rtl/afpm_io_sequencer.sv
// Byte-serial front end for the 16-bit logarithmic FP multiplier: gathers two
// operands low byte first, launches the core with a timeout, and streams the product back.
module afpm_io_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter logic [15:0] NAN_VALUE      = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        in_valid,
    input  logic [7:0]  byte_a,
    input  logic [7:0]  byte_b,
    output logic        in_ready,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        busy,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_LOAD_LO,
        ST_LOAD_HI,
        ST_LAUNCH,
        ST_WAIT,
        ST_OUT_LO,
        ST_OUT_HI
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic [15:0]      result;
    logic [15:0]      next_result;
    logic             capture_lo;
    logic             capture_hi;
    logic             set_err;

    assign in_ready = (state == ST_LOAD_LO) || (state == ST_LOAD_HI);
    assign busy     = (state != ST_LOAD_LO);

    // Pulse states only advance once their registered pulse has actually been
    // shown with ena high; a pulse cleared by ena=0 keeps the state so it is re-issued.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        next_result = result;
        capture_lo  = 1'b0;
        capture_hi  = 1'b0;
        set_err     = 1'b0;
        case (state)
            ST_LOAD_LO: begin
                if (in_valid) begin
                    capture_lo = 1'b1;
                    next_state = ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (in_valid) begin
                    capture_hi = 1'b1;
                    next_state = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (mul_start) begin
                    next_cnt   = '0;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_done) begin
                    next_result = mul_result;
                    next_state  = ST_OUT_LO;
                end else if (cnt == CNT_LAST) begin
                    next_result = NAN_VALUE;
                    set_err     = 1'b1;
                    next_state  = ST_OUT_LO;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            ST_OUT_LO: begin
                if (out_valid) next_state = ST_OUT_HI;
            end
            ST_OUT_HI: begin
                if (out_valid) next_state = ST_LOAD_LO;
            end
            default: next_state = ST_LOAD_LO;
        endcase
    end

    // Output pulses are registered from the state being entered, so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_LOAD_LO;
            cnt         <= '0;
            result      <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_byte    <= '0;
            mul_start   <= 1'b0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else if (!ena) begin
            mul_start <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            result <= next_result;
            if (capture_lo) begin
                mul_a[7:0] <= byte_a;
                mul_b[7:0] <= byte_b;
            end
            if (capture_hi) begin
                mul_a[15:8] <= byte_a;
                mul_b[15:8] <= byte_b;
            end
            if (set_err) timeout_err <= 1'b1;
            mul_start <= (next_state == ST_LAUNCH);
            out_valid <= (next_state == ST_OUT_LO) || (next_state == ST_OUT_HI);
            if (next_state == ST_OUT_LO)
                out_byte <= next_result[7:0];
            else if (next_state == ST_OUT_HI)
                out_byte <= next_result[15:8];
        end
    end

endmodule

// File: tb/tb_afpm_io_sequencer.sv
// Self-checking bench for afpm_io_sequencer: a transaction-level model predicts
// each launch and result byte, with directed cases plus randomized operations.
module tb_afpm_io_sequencer;

    localparam logic [15:0] NAN_VALUE = 16'h7E00;
    localparam int          TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  byte_a = 8'h00;
    logic [7:0]  byte_b = 8'h00;
    logic        in_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic [15:0] mul_result = 16'h0000;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        busy;
    logic        timeout_err;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        int          delay;
        bit          check_lat;
    } op_t;

    op_t         ops_q[$];
    int          bytes_left = 0;
    logic [15:0] exp_val = 16'h0000;
    logic [15:0] act_a = 16'h0000;
    logic [15:0] act_b = 16'h0000;
    bit          err_model = 1'b0;
    int          exp_lat = 0;
    bit          act_check_lat = 1'b0;
    int          start_cyc = 0;
    int          cyc = 0;

    bit          start_flag = 1'b0;
    int          cur_delay = 0;
    logic [15:0] cur_res = 16'h0000;
    bit          mul_pending = 1'b0;
    int          mul_count = 0;

    afpm_io_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .in_valid   (in_valid),
        .byte_a     (byte_a),
        .byte_b     (byte_b),
        .in_ready   (in_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_byte   (out_byte),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, actual, expected, cyc);
    endtask

    // Multiplier stand-in: answers a launch after a chosen number of WAIT cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mul_done = 1'b0;
            if (start_flag) begin
                start_flag  = 1'b0;
                mul_pending = 1'b1;
                mul_count   = cur_delay;
            end
            if (mul_pending) begin
                if (mul_count == 0) begin
                    mul_done    = 1'b1;
                    mul_result  = cur_res;
                    mul_pending = 1'b0;
                end else begin
                    mul_count--;
                end
            end
        end
    end

    // Scoreboard: a launch or byte only counts when seen with ena high.
    initial begin : scoreboard
        op_t op;
        bit  timed_out;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (!busy) checkOutput("idle_in_ready", in_ready, 1);
                if (ena && mul_start) begin
                    checkOutput("start_expected", ops_q.size() > 0, 1);
                    checkOutput("start_prev_done", bytes_left, 0);
                    if (ops_q.size() > 0) begin
                        op = ops_q.pop_front();
                        checkOutput("mul_a", mul_a, op.a);
                        checkOutput("mul_b", mul_b, op.b);
                        timed_out = (op.delay > TIMEOUT - 1);
                        exp_val   = timed_out ? NAN_VALUE : op.res;
                        if (timed_out) err_model = 1'b1;
                        exp_lat       = (timed_out ? TIMEOUT - 1 : op.delay) + 2;
                        act_check_lat = op.check_lat;
                        act_a         = op.a;
                        act_b         = op.b;
                        bytes_left    = 2;
                        start_cyc     = cyc;
                        cur_delay     = op.delay;
                        cur_res       = op.res;
                        start_flag    = 1'b1;
                    end
                end
                if (ena && out_valid) begin
                    checkOutput("out_expected", bytes_left > 0, 1);
                    checkOutput("out_in_ready", in_ready, 0);
                    checkOutput("out_hold_a", mul_a, act_a);
                    checkOutput("out_hold_b", mul_b, act_b);
                    checkOutput("out_err", timeout_err, err_model);
                    if (bytes_left == 2) begin
                        checkOutput("out_lo", out_byte, exp_val[7:0]);
                        if (act_check_lat) checkOutput("latency", cyc - start_cyc, exp_lat);
                    end else if (bytes_left == 1) begin
                        checkOutput("out_hi", out_byte, exp_val[15:8]);
                    end
                    if (bytes_left > 0) bytes_left--;
                end
            end
        end
    end

    task automatic sendByte(input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        bit acc = 1'b0;
        byte_a   = a;
        byte_b   = b;
        in_valid = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            if (in_ready && ena && rst_n) acc = 1'b1;
            waited++;
        end
        checkOutput("byte_accept", acc, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                                 input int delay, input int gap, input bit check_lat);
        op_t op;
        op.a = a; op.b = b; op.res = res; op.delay = delay; op.check_lat = check_lat;
        ops_q.push_back(op);
        sendByte(a[7:0], b[7:0]);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            checkOutput("gap_in_ready", in_ready, 1);
            checkOutput("gap_busy", busy, 1);
            checkOutput("gap_no_start", mul_start, 0);
            @(posedge clk);
            #1;
        end
        sendByte(a[15:8], b[15:8]);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((bytes_left != 0 || ops_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", bytes_left + ops_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ena      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ops_q.delete();
        bytes_left = 0;
        err_model  = 1'b0;
        checkOutput("rst_mul_a", mul_a, 16'h0000);
        checkOutput("rst_mul_b", mul_b, 16'h0000);
        checkOutput("rst_out_byte", out_byte, 8'h00);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_mul_start", mul_start, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rr;
        int          sel;
        int          dly;
        bit          found;
        int          n;

        doReset();

        // Basic operation with hand-computed timing
        applyStimulus(16'h3E00, 16'h4200, 16'h4480, 0, 0, 1'b1);
        checkOutput("t1_start", mul_start, 1);
        checkOutput("t1_mul_a", mul_a, 16'h3E00);
        checkOutput("t1_mul_b", mul_b, 16'h4200);
        @(posedge clk); #1;
        checkOutput("t1_start_once", mul_start, 0);
        @(posedge clk); #1;
        checkOutput("t1_valid_lo", out_valid, 1);
        checkOutput("t1_byte_lo", out_byte, 8'h80);
        @(posedge clk); #1;
        checkOutput("t1_valid_hi", out_valid, 1);
        checkOutput("t1_byte_hi", out_byte, 8'h44);
        @(posedge clk); #1;
        checkOutput("t1_valid_end", out_valid, 0);
        checkOutput("t1_in_ready", in_ready, 1);
        checkOutput("t1_byte_hold", out_byte, 8'h44);

        // Gapped high byte
        applyStimulus(16'h0101, 16'h0101, 16'h1234, 0, 5, 1'b1);
        waitDrain();
        checkOutput("gap_mul_a", mul_a, 16'h0101);
        checkOutput("gap_mul_b", mul_b, 16'h0101);

        // ena dropped for three cycles while the low result byte is up
        applyStimulus(16'h3E00, 16'h4200, 16'h4480, 0, 0, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            @(posedge clk); #1;
            if (out_valid) found = 1'b1;
            n++;
        end
        checkOutput("ena_found_lo", found, 1);
        ena = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("ena_hold_valid", out_valid, 0);
            checkOutput("ena_hold_byte", out_byte, 8'h80);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        checkOutput("ena_hold_valid", out_valid, 0);
        @(posedge clk); #1;
        checkOutput("ena_resume_valid", out_valid, 1);
        checkOutput("ena_resume_lo", out_byte, 8'h80);
        @(posedge clk); #1;
        checkOutput("ena_resume_valid", out_valid, 1);
        checkOutput("ena_resume_hi", out_byte, 8'h44);
        waitDrain();

        // Timeout, then a good operation keeps the sticky flag
        applyStimulus(16'h1234, 16'h5678, 16'hAAAA, 1000, 0, 1'b1);
        waitDrain();
        checkOutput("to_err", timeout_err, 1);
        checkOutput("to_byte_hi", out_byte, 8'h7E);
        applyStimulus(16'h3E00, 16'h4200, 16'h4480, 1, 1, 1'b1);
        waitDrain();
        checkOutput("to_err_sticky", timeout_err, 1);

        // mul_done on the final WAIT cycle wins
        doReset();
        applyStimulus(16'h3C00, 16'h3C00, 16'h3C00, TIMEOUT - 1, 0, 1'b1);
        waitDrain();
        checkOutput("last_cycle_err", timeout_err, 0);
        checkOutput("last_cycle_byte", out_byte, 8'h3C);

        // Reset in the middle of WAIT; the stale completion must be ignored
        applyStimulus(16'h1111, 16'h2222, 16'h5555, 8, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        doReset();
        applyStimulus(16'h3C00, 16'h3C00, 16'h3C00, 0, 0, 1'b1);
        waitDrain();
        checkOutput("rst_wait_byte", out_byte, 8'h3C);
        checkOutput("rst_wait_err", timeout_err, 0);

        // Randomized operations
        for (int k = 0; k < 25; k++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rr  = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6)       dly = $urandom_range(0, 3);
            else if (sel == 6) dly = TIMEOUT - 2;
            else if (sel == 7) dly = TIMEOUT - 1;
            else if (sel == 8) dly = TIMEOUT;
            else               dly = 1000;
            applyStimulus(ra, rb, rr, dly, $urandom_range(0, 3), 1'b1);
        end
        waitDrain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
